// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte register bank: pointer-addressed writes/reads,
// auto-increment with wrap, repeated START. Runs fully in the ACLK domain.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_AW     = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] peek_addr,
  output logic [7:0]        peek_data
);
  localparam int                NREG    = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          scl_q, sda_q;
  logic [2:0]          cnt_q, cnt_d;
  logic [6:0]          sh_q, sh_d;
  logic [REG_AW-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d, ack_ph_q, ack_ph_d, first_q, first_d;
  logic                sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          bank_q [NREG];
  logic                bank_we;

  // [0],[1] synchronize, [2] is history for edge detection
  logic scl_rise, scl_fall, start_ev, stop_ev, sda_s;
  logic [7:0] byte_in, rd_byte;
  assign sda_s    = sda_q[1];
  assign scl_rise =  scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] &  scl_q[2];
  assign start_ev =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_ev  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign byte_in  = {sh_q, sda_s};
  assign rd_byte  = bank_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_ph_d    = ack_ph_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_we     = 1'b0;
    if (start_ev) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_ev) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              busy_d   = 1'b1;
              rw_d     = byte_in[0];
              ack_ph_d = 1'b0;
              first_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        // First fall drives ACK; second fall ends the ACK slot
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else if (state_q == WR_ACK || !rw_q) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = WR_BYTE;
          end else begin
            sh_d     = rd_byte[6:0];
            sda_oe_d = ~rd_byte[7];
            cnt_d    = '0;
            state_d  = RD_BYTE;
          end
        end
        WR_BYTE: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d  = WR_ACK;
            ack_ph_d = 1'b0;
            if (first_q) begin
              ptr_d   = byte_in[REG_AW-1:0];
              first_d = 1'b0;
            end else begin
              bank_we     = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = byte_in;
              ptr_d       = ptr_q + PTR_ONE;
            end
          end
        end
        RD_BYTE: if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + PTR_ONE;
            ack_ph_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d = ~sh_q[6];
            sh_d     = {sh_q[5:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       ack_ph_d = 1'b1;
          end else if (scl_fall && ack_ph_q) begin
            sh_d     = rd_byte[6:0];
            sda_oe_d = ~rd_byte[7];
            cnt_d    = '0;
            state_d  = RD_BYTE;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_ph_q    <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      scl_q       <= {scl_q[1:0], scl_i};
      sda_q       <= {sda_q[1:0], sda_i};
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_ph_q    <= ack_ph_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (bank_we) bank_q[ptr_q] <= byte_in;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign peek_data = bank_q[peek_addr];
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master over an open-drain SDA model.
module tb_i2c_slave_responder;
  localparam time Q = 100;

  logic       ACLK = 1'b0, ARESETN = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_oe, busy, wr_strobe;
  logic [1:0] wr_addr, peek_addr = '0;
  logic [7:0] wr_data, peek_data;
  wire        sda_line = sda_m & ~sda_oe;

  int n_run = 0, n_fail = 0;
  int slog[$];
  logic oe_seen = 1'b0;

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .REG_AW(2)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .peek_addr(peek_addr), .peek_data(peek_data));

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (ARESETN && wr_strobe) slog.push_back(int'({wr_addr, wr_data}));
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int exp);
    int got;
    got = (slog.size() > 0) ? slog.pop_front() : -1;
    chk(tag, got, exp);
  endtask

  task automatic chk_peek(input string tag, input int idx, input logic [7:0] exp);
    peek_addr = 2'(idx);
    #1;
    chk(tag, {24'd0, peek_data}, {24'd0, exp});
  endtask

  task automatic start_c();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic bitx(input logic b, output logic r);
    sda_m = b; #Q; scl_m = 1'b1; #Q; r = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(d[i], r);
    bitx(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, r);
      d[i] = r;
    end
    bitx(nack, r);
  endtask

  initial begin
    logic a, r;
    logic [7:0] d;
    #1;
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_strobe", {31'd0, wr_strobe}, 0);
    chk("rst_wr_addr", {30'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk_peek("rst_bank0", 0, 8'h00);
    #50 ARESETN = 1'b1;
    #(2*Q);

    // write ptr 1, A5, 3C
    start_c();
    wbyte(8'hA0, a); chk("t1_ack_addr", {31'd0, a}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    wbyte(8'h01, a); chk("t1_ack_ptr", {31'd0, a}, 1);
    wbyte(8'hA5, a); chk("t1_ack_d0", {31'd0, a}, 1);
    wbyte(8'h3C, a); chk("t1_ack_d1", {31'd0, a}, 1);
    stop_c(); #Q;
    chk("t1_busy_off", {31'd0, busy}, 0);
    chk_strobe("t1_strobe0", 32'h1A5);
    chk_strobe("t1_strobe1", 32'h23C);
    chk("t1_nstrobe", slog.size(), 0);
    chk_peek("t1_peek1", 1, 8'hA5);
    chk_peek("t1_peek2", 2, 8'h3C);

    // ptr 1, repeated START, read 3 bytes
    start_c();
    wbyte(8'hA0, a); chk("t3_ack_addr", {31'd0, a}, 1);
    wbyte(8'h01, a); chk("t3_ack_ptr", {31'd0, a}, 1);
    start_c();
    wbyte(8'hA1, a); chk("t3_ack_raddr", {31'd0, a}, 1);
    rbyte(1'b0, d); chk("t3_rd0", {24'd0, d}, 32'hA5);
    rbyte(1'b0, d); chk("t3_rd1", {24'd0, d}, 32'h3C);
    rbyte(1'b1, d); chk("t3_rd2", {24'd0, d}, 32'h00);
    chk("t3_oe_rel", {31'd0, sda_oe}, 0);
    chk("t3_busy_pre", {31'd0, busy}, 1);
    stop_c(); #Q;
    chk("t3_busy_off", {31'd0, busy}, 0);
    chk("t3_nstrobe", slog.size(), 0);

    // pointer wrap
    start_c();
    wbyte(8'hA0, a); wbyte(8'h03, a); wbyte(8'h11, a); wbyte(8'h22, a);
    chk("t2_ack_last", {31'd0, a}, 1);
    stop_c(); #Q;
    chk_strobe("t2_strobe0", 32'h311);
    chk_strobe("t2_strobe1", 32'h022);
    chk_peek("t2_peek3", 3, 8'h11);
    chk_peek("t2_peek0", 0, 8'h22);
    chk_peek("t2_peek1", 1, 8'hA5);

    // foreign address
    oe_seen = 1'b0;
    start_c();
    wbyte(8'hA2, a); chk("t4_nack_addr", {31'd0, a}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    wbyte(8'h55, a); chk("t4_nack_data", {31'd0, a}, 0);
    stop_c(); #Q;
    chk("t4_oe_seen", {31'd0, oe_seen}, 0);
    chk("t4_nstrobe", slog.size(), 0);
    chk_peek("t4_peek1", 1, 8'hA5);
    chk_peek("t4_peek0", 0, 8'h22);

    // STOP mid-byte: nothing committed, ptr (2) retained
    start_c();
    wbyte(8'hA0, a); wbyte(8'h02, a);
    bitx(1'b1, r); bitx(1'b0, r); bitx(1'b1, r); bitx(1'b0, r);
    stop_c(); #Q;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_nstrobe", slog.size(), 0);
    chk_peek("t6_peek2", 2, 8'h3C);
    start_c();
    wbyte(8'hA1, a); chk("t6_ack_raddr", {31'd0, a}, 1);
    rbyte(1'b1, d); chk("t6_rd_ptr", {24'd0, d}, 32'h3C);
    stop_c(); #Q;

    // reset during 5th bit of a read of bank[0]=0x22 (bit 3 is 0 -> driven)
    start_c();
    wbyte(8'hA0, a); wbyte(8'h00, a);
    start_c();
    wbyte(8'hA1, a); chk("t5_ack_raddr", {31'd0, a}, 1);
    for (int i = 0; i < 4; i++) bitx(1'b1, r);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #(Q/2);
    chk("t5_oe_before", {31'd0, sda_oe}, 1);
    ARESETN = 1'b0; #1;
    chk("t5_oe_async", {31'd0, sda_oe}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) chk_peek("t5_bank_clr", i, 8'h00);
    #Q; ARESETN = 1'b1; #Q;
    start_c();
    wbyte(8'hA0, a); chk("t5_ack_after", {31'd0, a}, 1);
    stop_c(); #Q;
    chk("t5_busy_off", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
